// File: rtl/uart_rx_fifo_core_pkg.sv
// Shared types for the UART receiver: parity mode, FSM states, per-word status
// and the clock divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  // 'break' is a keyword, hence brk.
  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_status_t;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_core_if.sv
// Valid/ready stream carrying one received word plus its status flags.
interface uart_rx_fifo_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_break;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_break, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_break, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo_core_sync_fifo.sv
// Synchronous show-ahead FIFO; a pop frees a slot for a push in the same cycle,
// even when full.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; head is masked while empty so reset still reads 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/uart_rx_fifo_core.sv
// Oversampled UART receiver with majority vote, break/overrun detection and an
// output FIFO. Define UART_RX_PARITY_EN to compile in the parity bit and check.
module uart_rx_fifo_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  uart_rx_fifo_core_if.master stream,
  output logic                rx_overrun,
  output logic                rx_busy
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int W   = DATA_BITS + 3;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = (PARITY != 0);
`else
  // PARITY is accepted but has no effect in this build.
  localparam bit PAR_EN = 1'b0 && (PARITY != 0);
`endif

  rx_state_e            state;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        samp_cnt;
  logic                 v0, v1, maj, tick, mid, bit_end;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt, last_stop;
  logic [DATA_BITS-1:0] shreg;
  logic                 all_zero, ferr, perr_bit, push, pop;
  rx_status_t           push_stat, head_stat;
  logic [W-1:0]         push_word, head_word;
  logic                 fifo_full, fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick      = (tick_cnt == TW'(DIV - 1));
  assign mid       = tick && (samp_cnt == SW'(OVERSAMPLE / 2 + 1));
  assign bit_end   = tick && (samp_cnt == SW'(OVERSAMPLE - 1));
  assign maj       = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
  assign push      = reset_n && (state == STOP) && mid && last_stop;

`ifdef UART_RX_PARITY_EN
  logic perr;
  assign perr_bit = perr;
`else
  assign perr_bit = 1'b0;
`endif

  always_comb begin
    // NOTE: default every field first so no path through the block infers a latch.
    push_stat            = '0;
    push_stat.brk        = all_zero && (stop_cnt || !maj);
    push_stat.frame_err  = ferr || !maj;
    push_stat.parity_err = perr_bit;
  end

  assign push_word = {push_stat, push_stat.brk ? '0 : shreg};

  // NOTE: all state updates use <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      samp_cnt <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      all_zero <= 1'b0;
      ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      // Counters idle at 0 so the first tick after a start edge is phase aligned.
      if (state == IDLE || state == BRK_WAIT) begin
        tick_cnt <= '0;
        samp_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (tick && samp_cnt == SW'(OVERSAMPLE / 2 - 1)) v0 <= rx_s;
      if (tick && samp_cnt == SW'(OVERSAMPLE / 2))     v1 <= rx_s;

      case (state)
        IDLE: if (!rx_s) begin
          state    <= START;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          all_zero <= 1'b1;
          ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
          perr     <= 1'b0;
`endif
        end
        START: begin
          if (mid && maj)   state <= IDLE;
          else if (bit_end) state <= DATA;
        end
        DATA: begin
          if (mid) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (maj) all_zero <= 1'b0;
          end
          if (bit_end) begin
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              if (PAR_EN) state <= uart_pkg::PARITY;
              else        state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        uart_pkg::PARITY: begin
          if (mid) begin
            perr <= ((^shreg) ^ maj) != (parity_e'(PARITY) == PAR_ODD);
            if (maj) all_zero <= 1'b0;
          end
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          if (mid) begin
            if (!maj) ferr <= 1'b1;
            if (maj && !stop_cnt) all_zero <= 1'b0;
            if (last_stop) state <= push_stat.brk ? BRK_WAIT : IDLE;
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end
        BRK_WAIT: if (rx_s) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign pop = !fifo_empty && stream.rx_ready;

  uart_rx_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_stat            = head_word[W-1:DATA_BITS];
  assign stream.rx_data       = head_word[DATA_BITS-1:0];
  assign stream.rx_break      = head_stat.brk;
  assign stream.rx_frame_err  = head_stat.frame_err;
  assign stream.rx_parity_err = head_stat.parity_err;
  assign stream.rx_valid      = !fifo_empty;
  assign rx_overrun           = push && fifo_full && !pop;
  assign rx_busy              = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Directed/randomized bench for uart_rx_fifo_core against a frame-level model.
module tb_uart_rx_fifo_core;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7, SB = 2, PAR = 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int DB = 8, SB = 1, PAR = 0;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int OS       = 8;
  localparam int DIV      = 27;
  localparam int BAUD     = 115200;
  localparam int CLK_FREQ = DIV * OS * BAUD;
  localparam int BIT_CLK  = DIV * OS;
  localparam int DEPTH    = 4;

  typedef struct packed {
    logic          brk;
    logic          ferr;
    logic          perr;
    logic [DB-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  logic rx_overrun, rx_busy;

  uart_rx_fifo_core_if #(.DATA_BITS(DB)) stream ();

  uart_rx_fifo_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .STOP_BITS  (SB),
    .PARITY     (PAR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .stream     (stream),
    .rx_overrun (rx_overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    ovr_cnt = 0;
  word_t got_q[$];
  word_t exp_q[$];

  always @(negedge clk) begin
    if (reset_n && stream.rx_valid && stream.rx_ready)
      got_q.push_back({stream.rx_break, stream.rx_frame_err, stream.rx_parity_err, stream.rx_data});
    if (rx_overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected word for one frame, straight from the line-level rules.
  function automatic word_t model(input logic [8:0] d, input bit bad_par, input bit stop0_low);
    word_t         w;
    logic [DB-1:0] dd;
    logic          pbit;
    dd     = d[DB-1:0];
    pbit   = (^dd) ^ (PAR == 2) ^ bad_par;
    w.data = dd;
    w.perr = PAR_EN ? (((^dd) ^ pbit) != (PAR == 2)) : 1'b0;
    w.ferr = stop0_low;
    w.brk  = (dd == '0) && (!PAR_EN || !pbit) && stop0_low;
    if (w.brk) w.data = '0;
    return w;
  endfunction

  task automatic drive_bit(input logic v, input bit noisy);
    int off;
    rx = v;
    if (noisy) begin
      off = BIT_CLK / 2 - 10 + $urandom_range(0, 60);
      repeat (off) step();
      rx = ~v;
      repeat (8) step();
      rx = v;
      repeat (BIT_CLK - off - 8) step();
    end else begin
      repeat (BIT_CLK) step();
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input bit bad_par, input bit stop0_low, input bit noisy);
    logic pbit;
    pbit = (^d[DB-1:0]) ^ (PAR == 2) ^ bad_par;
    drive_bit(1'b0, noisy);
    for (int i = 0; i < DB; i++) drive_bit(d[i], noisy);
    if (PAR_EN) drive_bit(pbit, noisy);
    for (int i = 0; i < SB; i++) drive_bit((i == 0) ? !stop0_low : 1'b1, noisy);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLK) step();
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, stream.rx_valid, 0);
    check({tag, "_head"}, {stream.rx_break, stream.rx_frame_err, stream.rx_parity_err, stream.rx_data}, 0);
    check({tag, "_busy"}, rx_busy, 0);
    check({tag, "_ovr"}, rx_overrun, 0);
  endtask

  initial begin
    logic [8:0] d;
    word_t      held;
    int         n0;

    stream.rx_ready = 1'b0;
    repeat (5) step();
    reset_n = 1'b1;
    step();
    check_outputs_zero("reset");

    // Two clean frames, consumer always ready.
    stream.rx_ready = 1'b1;
    send_frame(9'h0A5, 0, 0, 0); exp_q.push_back(model(9'h0A5, 0, 0));
    send_frame(9'h03C, 0, 0, 0); exp_q.push_back(model(9'h03C, 0, 0));
    idle_bits(2);
    wait_words(2, 4 * BIT_CLK);
    compare_words("basic");
    check("basic_no_ovr", ovr_cnt, 0);

    // Wrong parity bit (ignored when parity is compiled out).
    send_frame(9'h041, 1, 0, 0); exp_q.push_back(model(9'h041, 1, 0));
    idle_bits(2);
    wait_words(1, 4 * BIT_CLK);
    compare_words("parity");

    // First stop bit forced low.
    send_frame(9'h055, 0, 1, 0); exp_q.push_back(model(9'h055, 0, 1));
    idle_bits(2);
    wait_words(1, 4 * BIT_CLK);
    compare_words("frame");

    // Break: 12 bit times low, then line back high.
    rx = 1'b0;
    repeat (12 * BIT_CLK) step();
    check("break_busy_low", rx_busy, 1);
    check("break_one_word_low", got_q.size(), 1);
    idle_bits(2);
    check("break_idle", rx_busy, 0);
    exp_q.push_back(model(9'h000, 0, 1));
    compare_words("break");

    // Overrun: consumer stalled, DEPTH+1 frames back to back.
    stream.rx_ready = 1'b0;
    n0 = ovr_cnt;
    for (int i = 0; i <= DEPTH; i++) begin
      d = 9'($urandom);
      send_frame(d, 0, 0, 0);
      if (i < DEPTH) exp_q.push_back(model(d, 0, 0));
    end
    idle_bits(2);
    check("ovr_pulses", ovr_cnt - n0, 1);
    check("ovr_valid", stream.rx_valid, 1);
    held = {stream.rx_break, stream.rx_frame_err, stream.rx_parity_err, stream.rx_data};
    repeat (20) step();
    check("ovr_stable", {stream.rx_break, stream.rx_frame_err, stream.rx_parity_err, stream.rx_data}, held);
    check("ovr_head", held, exp_q[0]);
    stream.rx_ready = 1'b1;
    wait_words(DEPTH, 100);
    step();
    check("ovr_drained", stream.rx_valid, 0);
    compare_words("ovr");

    // Glitch: 3-clock low pulse is a false start.
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (2) step();
    check("glitch_busy", rx_busy, 1);
    idle_bits(1);
    check("glitch_idle", rx_busy, 0);
    compare_words("glitch");

    // Random frames, alternating clean and with one inverted sample per bit.
    for (int i = 0; i < 6; i++) begin
      d = 9'($urandom);
      send_frame(d, 0, 0, i[0]);
      exp_q.push_back(model(d, 0, 0));
    end
    idle_bits(2);
    wait_words(6, 4 * BIT_CLK);
    compare_words("noise");

    // Reset in the middle of DATA, with a word already buffered.
    stream.rx_ready = 1'b0;
    send_frame(9'h05A, 0, 0, 0);
    idle_bits(1);
    check("pre_reset_valid", stream.rx_valid, 1);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) drive_bit(i[0], 0);
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check_outputs_zero("midreset");
    idle_bits(2);
    check("midreset_no_push", stream.rx_valid, 0);
    stream.rx_ready = 1'b1;
    send_frame(9'h0C3, 0, 0, 0); exp_q.push_back(model(9'h0C3, 0, 0));
    idle_bits(2);
    wait_words(1, 4 * BIT_CLK);
    compare_words("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo_core.md
# uart_rx_fifo_core

Parametrised UART receiver: 5–9 data bits, optional parity, 1 or 2 stop bits, oversampled with a 3-sample majority vote. Received words and per-word status flags are buffered in a small FIFO and delivered on a valid/ready stream. It replaces the fixed 8N1 receiver at the serial front end, feeding the command parser. Break and overrun detection are added.

## Interface
- CLK_FREQ, 50_000_000, system clock in Hz
- BAUD_RATE, 115200, line rate in bit/s
- OVERSAMPLE, 16, samples per bit; even, ≥8
- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- STOP_BITS, 1, 1 or 2
- PARITY, 0, 0 none / 1 even / 2 odd; ignored unless UART_RX_PARITY_EN defined
- FIFO_DEPTH, 4, power of two, ≥2

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  head-of-FIFO word
- rx_parity_err  out  1  head word failed parity
- rx_frame_err  out  1  head word had a 0 stop bit
- rx_break  out  1  head word is a break condition
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head word when valid && ready
- rx_overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full
- rx_busy  out  1  FSM not in IDLE

## Operation
- rx passes through a 2-FF synchroniser. Both flops reset to 1.
- A tick counter divides clk by DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE). It is held at 0 in IDLE and restarts on start-edge detection so that phase aligns to the edge.
- A sample counter counts ticks 0..OVERSAMPLE-1 per bit. The bit value is the majority of samples OVERSAMPLE/2-1, /2, /2+1.
- FSM states and transitions:
  - IDLE → START on synchronised rx = 0.
  - START: a majority of 1 means a false start → IDLE. Otherwise the state runs to the end of the bit → DATA.
  - DATA: shifts DATA_BITS bits into the shift register, LSB first, then → PARITY if parity is enabled, else → STOP.
  - PARITY: computes the error as XOR(data, parity bit) ≠ (PARITY==2), then → STOP.
  - STOP: samples each stop bit. At the mid-bit of the last stop bit the word is decided and pushed, then → IDLE. If the word is a break → BRK_WAIT instead.
  - BRK_WAIT: waits for synchronised rx = 1, then → IDLE. No further pushes occur until then.
- frame_err is set if any stop bit sampled is 0.
- break is set when all data bits, the parity bit (if present) and the first stop bit are 0. A break word pushes data = 0 with frame_err = 1 and break = 1.
- Push entry = {break, frame_err, parity_err, data}, width DATA_BITS+3.
- If the FIFO is full at push, the word is discarded, rx_overrun pulses for 1 cycle, and FIFO contents are unchanged.
- Pop happens on rx_valid && rx_ready.
- Push and pop in the same cycle are both performed, including when the FIFO is full: pop frees the slot and the push is accepted, with no overrun.

## Timing
- Reset (reset_n = 0 at a clk edge): FSM = IDLE, counters 0, FIFO empty. All outputs are 0: rx_data, the flags, rx_valid, rx_overrun and rx_busy.
- reset_n asserted mid-frame aborts the frame. No push occurs. Reception restarts on the first falling edge after release.
- Latency is 1 clk from the push decision (mid last stop bit) to rx_valid = 1 on an empty FIFO. FIFO outputs are show-ahead and registered.
- rx_data and the flags are stable while rx_valid && !rx_ready.
- Back-to-back frames are supported: start detection is enabled from the cycle after the push, i.e. in the second half of the stop bit.
- rx_overrun is asserted in the same cycle the push would have occurred.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state and parity check are compiled in, and the PARITY parameter is honoured.
- Not defined: the PARITY state is absent, the frame has no parity bit, and rx_parity_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the parity enum (PAR_NONE/PAR_EVEN/PAR_ODD);
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT);
  - the rx status struct {break, frame_err, parity_err};
  - a function computing DIV.
- Sub-module uart_rx_sync_fifo: a synchronous show-ahead FIFO parametrised by WIDTH and DEPTH, with full/empty outputs and simultaneous push/pop support.

## Test plan
- 8N1 at DIV = 27, send 0xA5 then 0x3C with rx_ready = 1 → two pops, 0xA5 then 0x3C, all flags 0, rx_overrun never asserted.
- DATA_BITS = 7, even parity, 2 stop bits (macro on), send 0x41 with wrong parity bit → rx_data = 0x41, rx_parity_err = 1, rx_frame_err = 0.
- Stop bit forced 0 on 0x55 → rx_frame_err = 1, rx_break = 0. A 12-bit-time low pulse → one word with data 0 and break = 1, then no further words until rx returns high.
- rx_ready = 0, send FIFO_DEPTH+1 frames → FIFO full, rx_overrun pulses once on the last frame. Draining returns the first FIFO_DEPTH words in order.
- Glitch: rx low for 3 clk only → no push, FSM back to IDLE. Noise: single-sample inversion inside each bit → correct data recovered by the majority vote.
- reset_n pulsed low mid-DATA → no word pushed, outputs 0. The next clean frame 0xC3 is received correctly.
